// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xor_cipher_pkg                                            |
// | Brief    : Shared types and constants for the streaming XOR cipher.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package xor_cipher_pkg;

  // Control states of the cipher top.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    READY    = 2'd2,
    STREAM   = 2'd3
  } state_e;

  // Keystream modes, latched at message start.
  localparam logic MODE_REPEAT = 1'b0;
  localparam logic MODE_LFSR   = 1'b1;

  // Default Galois feedback mask for a 32-bit key.
  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

endpackage : xor_cipher_pkg
`default_nettype wire

// File: rtl/keystream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : keystream_gen                                             |
// | Brief    : Working keystream register w with rotate / Galois-LFSR    |
// |            update rules; ks_o is the current keystream bit.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module keystream_gen
  import xor_cipher_pkg::*;
#(
  parameter int unsigned      KEY_W     = 32,
  parameter logic [KEY_W-1:0] LFSR_TAPS = KEY_W'(DEFAULT_LFSR_TAPS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             mode_i,
  input  logic [KEY_W-1:0] seed_i,
  output logic             ks_o
);

  logic [KEY_W-1:0] w_q;
  logic [KEY_W-1:0] w_d;

  // Next value of w: reload from the seed wins over stepping.
  always_comb begin
    w_d = w_q;
    if (load_i) begin
      w_d = seed_i;
    end else if (step_i) begin
      if (mode_i == MODE_LFSR) begin
        w_d = {w_q[KEY_W-2:0], 1'b0} ^ (w_q[KEY_W-1] ? LFSR_TAPS : '0);
      end else begin
        w_d = {w_q[KEY_W-2:0], w_q[KEY_W-1]};
      end
    end
  end

  // Working register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign ks_o = w_q[KEY_W-1];

endmodule : keystream_gen
`default_nettype wire

// File: rtl/xor_stream_cipher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xor_stream_cipher                                         |
// | Brief    : Serial-key, serial-message XOR stream cipher with         |
// |            repeating-key and LFSR keystream modes and protocol       |
// |            error reporting.                                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int unsigned      KEY_W     = 32,
  parameter int unsigned      MSG_W     = 512,
  parameter logic [KEY_W-1:0] LFSR_TAPS = KEY_W'(DEFAULT_LFSR_TAPS)
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iLoad_key,
  input  logic iLoad_msg,
  input  logic iSerial_in,
  input  logic iMode,
  output logic oSerial_out,
  output logic oSerial_start,
  output logic oSerial_end,
  output logic oKey_ready,
  output logic oError
);

  localparam int unsigned      KCW      = $clog2(KEY_W + 1);
  localparam int unsigned      MCW      = $clog2(MSG_W + 1);
  localparam logic [KCW-1:0]   KEY_LAST = KCW'(KEY_W - 1);
  localparam logic [MCW-1:0]   MSG_LAST = MCW'(MSG_W - 1);
  localparam logic [KCW-1:0]   KCNT_ONE = KCW'(1);
  localparam logic [MCW-1:0]   MCNT_ONE = MCW'(1);

  state_e           state_q;
  logic [KEY_W-1:0] key_sr_q;
  logic [KCW-1:0]   key_cnt_q;
  logic [MCW-1:0]   msg_cnt_q;
  logic             key_ready_q;
  logic             out_q;
  logic             start_q;
  logic             end_q;
  logic             err_q;
  logic             lk_prev_q;
  logic             lm_prev_q;
  logic             din_q;      // message bit from the previous enabled edge
  logic             mode_q;

  logic             lk_rise;
  logic             lm_rise;
  logic             msg_last;
  logic             msg_start;
  logic             ks_step;
  logic             ks;
  logic [KEY_W-1:0] key_shift;

  // Framing edges and keystream control; a message may also restart on the
  // final STREAM edge so back-to-back messages need no gap cycle.
  always_comb begin
    lk_rise   = iLoad_key & ~lk_prev_q;
    lm_rise   = iLoad_msg & ~lm_prev_q;
    msg_last  = (msg_cnt_q == MSG_LAST);
    key_shift = {key_sr_q[KEY_W-2:0], iSerial_in};
    msg_start = 1'b0;
    ks_step   = 1'b0;
    if (iEn) begin
      case (state_q)
        READY:   msg_start = iLoad_msg & ~lk_rise;
        STREAM: begin
          ks_step   = 1'b1;
          msg_start = msg_last & iLoad_msg;
        end
        default: msg_start = 1'b0;
      endcase
    end
  end

  keystream_gen #(
    .KEY_W     (KEY_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_keystream_gen (
    .clk_i  (iClk),
    .rst_ni (iRst),
    .load_i (msg_start),
    .step_i (ks_step),
    .mode_i (mode_q),
    .seed_i (key_sr_q),
    .ks_o   (ks)
  );

  // Control FSM with key register, counters and registered outputs.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= IDLE;
      key_sr_q    <= '0;
      key_cnt_q   <= '0;
      msg_cnt_q   <= '0;
      key_ready_q <= 1'b0;
      out_q       <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
      lk_prev_q   <= 1'b0;
      lm_prev_q   <= 1'b0;
      din_q       <= 1'b0;
      mode_q      <= MODE_REPEAT;
    end else if (!iEn) begin
      // Frozen: only the strobes drop so no output bit is reported twice.
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      lk_prev_q <= iLoad_key;
      lm_prev_q <= iLoad_msg;
      din_q     <= iSerial_in;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      if (msg_start) begin
        mode_q <= iMode;
      end
      case (state_q)
        IDLE: begin
          if (lm_rise) begin
            err_q <= 1'b1;
          end
          if (iLoad_key) begin
            key_sr_q  <= key_shift;
            key_cnt_q <= KCNT_ONE;
            state_q   <= LOAD_KEY;
          end
        end
        LOAD_KEY: begin
          if (lm_rise) begin
            err_q <= 1'b1;
          end
          if (iLoad_key) begin
            key_sr_q  <= key_shift;
            key_cnt_q <= key_cnt_q + KCNT_ONE;
            if (key_cnt_q == KEY_LAST) begin
              key_ready_q <= 1'b1;
              state_q     <= READY;
            end
          end else begin
            err_q     <= 1'b1;
            key_sr_q  <= '0;
            key_cnt_q <= '0;
            state_q   <= IDLE;
          end
        end
        READY: begin
          if (lk_rise && lm_rise) begin
            err_q <= 1'b1;
          end else if (lk_rise) begin
            key_ready_q <= 1'b0;
            key_sr_q    <= key_shift;
            key_cnt_q   <= KCNT_ONE;
            state_q     <= LOAD_KEY;
          end else if (iLoad_msg) begin
            msg_cnt_q <= '0;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          out_q   <= din_q ^ ks;
          start_q <= 1'b1;
          if (msg_last) begin
            end_q <= 1'b1;
            if (iLoad_msg) begin
              msg_cnt_q <= '0;
            end else begin
              msg_cnt_q <= msg_cnt_q + MCNT_ONE;
              state_q   <= READY;
            end
          end else if (!iLoad_msg) begin
            err_q     <= 1'b1;
            msg_cnt_q <= msg_cnt_q + MCNT_ONE;
            state_q   <= READY;
          end else begin
            msg_cnt_q <= msg_cnt_q + MCNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oSerial_out   = out_q;
  assign oSerial_start = start_q;
  assign oSerial_end   = end_q;
  assign oKey_ready    = key_ready_q;
  assign oError        = err_q;

endmodule : xor_stream_cipher
`default_nettype wire

// File: tb/tb_xor_stream_cipher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_xor_stream_cipher                                      |
// | Brief    : Directed/randomised self-checking bench for the streaming |
// |            XOR cipher against a bit-level keystream model.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_xor_stream_cipher;
  import xor_cipher_pkg::*;

  localparam int unsigned      KEY_W = 32;
  localparam int unsigned      MSG_W = 512;
  localparam logic [KEY_W-1:0] TAPS  = 32'h8020_0003;

  logic iClk = 1'b0;
  logic iRst, iEn, iLoad_key, iLoad_msg, iSerial_in, iMode;
  logic oSerial_out, oSerial_start, oSerial_end, oKey_ready, oError;

  int errors = 0;
  int checks = 0;

  // Monitor state (written only by the monitor process).
  logic out_bits[$];
  int   end_idx[$];
  int   end_run[$];
  int   n_err = 0;
  int   run   = 0;

  xor_stream_cipher #(
    .KEY_W     (KEY_W),
    .MSG_W     (MSG_W),
    .LFSR_TAPS (TAPS)
  ) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iEn           (iEn),
    .iLoad_key     (iLoad_key),
    .iLoad_msg     (iLoad_msg),
    .iSerial_in    (iSerial_in),
    .iMode         (iMode),
    .oSerial_out   (oSerial_out),
    .oSerial_start (oSerial_start),
    .oSerial_end   (oSerial_end),
    .oKey_ready    (oKey_ready),
    .oError        (oError)
  );

  always #5 iClk = ~iClk;

  // Collect valid ciphertext bits, end positions and error pulses.
  always @(negedge iClk) begin
    if (iRst) begin
      if (oSerial_end) begin
        end_idx.push_back(out_bits.size());
        end_run.push_back(run + 1);
      end
      if (oSerial_start) out_bits.push_back(oSerial_out);
      if (oError) n_err <= n_err + 1;
      run <= oSerial_start ? run + 1 : 0;
    end else begin
      run <= 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: ciphertext = message XOR keystream, keystream either the key
  // bits repeated MSB first or the MSB sequence of a Galois LFSR seeded by key.
  function automatic logic [MSG_W-1:0] model(input logic [MSG_W-1:0] msg,
                                             input logic [KEY_W-1:0] key,
                                             input logic lfsr);
    logic [MSG_W-1:0] r;
    logic [KEY_W-1:0] s;
    logic             k;
    s = key;
    r = '0;
    for (int i = 0; i < MSG_W; i++) begin
      if (lfsr) begin
        k = s[KEY_W-1];
        s = (s << 1) ^ (k ? TAPS : '0);
      end else begin
        k = key[KEY_W-1-(i % KEY_W)];
      end
      r[MSG_W-1-i] = msg[MSG_W-1-i] ^ k;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [MSG_W-1:0] obs,
                       input logic [MSG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic lk, input logic lm, input logic d,
                     input logic md, input logic en);
    iLoad_key  = lk;
    iLoad_msg  = lm;
    iSerial_in = d;
    iMode      = md;
    iEn        = en;
    @(posedge iClk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load_key(input logic [KEY_W-1:0] key, input int nbits);
    for (int i = 0; i < nbits; i++) cyc(1'b1, 1'b0, key[KEY_W-1-i], 1'b0, 1'b1);
  endtask

  task automatic send_msg(input logic [MSG_W-1:0] msg, input logic md, input int nbits);
    for (int i = 0; i < nbits; i++) cyc(1'b0, 1'b1, msg[MSG_W-1-i], md, 1'b1);
  endtask

  task automatic grab(input int base, input int n, output logic [MSG_W-1:0] v);
    v = '0;
    for (int i = 0; i < n; i++)
      if (base + i < out_bits.size()) v[MSG_W-1-i] = out_bits[base+i];
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m;
    for (int i = 0; i < MSG_W; i++) m[i] = 1'($urandom_range(0, 1));
    return m;
  endfunction

  initial begin
    logic [KEY_W-1:0] key;
    logic [MSG_W-1:0] m1, m2, got;
    logic             md;
    int base, e0, ee0, bad;

    iRst = 1'b0; iEn = 1'b0; iLoad_key = 1'b0; iLoad_msg = 1'b0;
    iSerial_in = 1'b0; iMode = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    check("reset_out",   MSG_W'(oSerial_out),   '0);
    check("reset_start", MSG_W'(oSerial_start), '0);
    check("reset_end",   MSG_W'(oSerial_end),   '0);
    check("reset_ready", MSG_W'(oKey_ready),    '0);
    check("reset_error", MSG_W'(oError),        '0);
    iRst = 1'b1;
    idle(2);

    // Repeating key over an all-zero message.
    key = 32'hA5A5A5A5;
    load_key(key, KEY_W - 1);
    check("ready_before_last", MSG_W'(oKey_ready), '0);
    cyc(1'b1, 1'b0, key[0], 1'b0, 1'b1);
    check("ready_at_last", MSG_W'(oKey_ready), MSG_W'(1));
    idle(1);
    base = out_bits.size(); e0 = end_idx.size(); ee0 = n_err;
    send_msg('0, MODE_REPEAT, MSG_W);
    idle(3);
    grab(base, MSG_W, got);
    check("t1_cipher", got, {16{32'hA5A5A5A5}});
    check("t1_count", MSG_W'(out_bits.size() - base), MSG_W'(MSG_W));
    check("t1_end_count", MSG_W'(end_idx.size() - e0), MSG_W'(1));
    if (end_idx.size() > e0) begin
      check("t1_end_idx", MSG_W'(end_idx[e0]), MSG_W'(base + MSG_W - 1));
      check("t1_start_run", MSG_W'(end_run[e0]), MSG_W'(MSG_W));
    end
    check("t1_no_error", MSG_W'(n_err - ee0), '0);

    // LFSR keystream from key 1.
    key = 32'h0000_0001;
    load_key(key, KEY_W);
    idle(1);
    base = out_bits.size();
    send_msg('0, MODE_LFSR, MSG_W);
    idle(3);
    grab(base, MSG_W, got);
    check("t2_bit31", MSG_W'(got[MSG_W-1-31]), MSG_W'(1));
    check("t2_bit32", MSG_W'(got[MSG_W-1-32]), MSG_W'(1));
    check("t2_bits0_30", MSG_W'(got[MSG_W-1 -: 31]), '0);
    check("t2_cipher", got, model('0, key, 1'b1));

    // Back-to-back messages with a random key, repeating mode.
    key = $urandom;
    load_key(key, KEY_W);
    idle(1);
    base = out_bits.size(); e0 = end_idx.size();
    m1 = '1; m2 = '0;
    send_msg(m1, MODE_REPEAT, MSG_W);
    send_msg(m2, MODE_REPEAT, MSG_W);
    idle(3);
    grab(base, MSG_W, got);
    check("t3_msg1", got, model(m1, key, 1'b0));
    grab(base + MSG_W, MSG_W, got);
    check("t3_msg2", got, model(m2, key, 1'b0));
    check("t3_end_count", MSG_W'(end_idx.size() - e0), MSG_W'(2));
    if (end_run.size() > e0 + 1)
      check("t3_no_gap", MSG_W'(end_run[e0+1]), MSG_W'(2 * MSG_W));

    // Key load aborted after 10 bits, then a message request with no key.
    ee0 = n_err;
    load_key($urandom, 10);
    idle(2);
    check("t4_abort_error", MSG_W'(n_err - ee0), MSG_W'(1));
    check("t4_ready_low", MSG_W'(oKey_ready), '0);
    base = out_bits.size(); ee0 = n_err;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    check("t4_msg_no_key_error", MSG_W'(n_err - ee0), MSG_W'(1));
    check("t4_no_output", MSG_W'(out_bits.size() - base), '0);

    // Message aborted after 100 bits, then a full LFSR message.
    key = $urandom;
    load_key(key, KEY_W);
    idle(1);
    base = out_bits.size(); e0 = end_idx.size(); ee0 = n_err;
    m1 = rand_msg();
    send_msg(m1, MODE_REPEAT, 100);
    idle(3);
    check("t5_count", MSG_W'(out_bits.size() - base), MSG_W'(100));
    check("t5_error", MSG_W'(n_err - ee0), MSG_W'(1));
    check("t5_no_end", MSG_W'(end_idx.size() - e0), '0);
    grab(base, 100, got);
    m2 = model(m1, key, 1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) if (got[MSG_W-1-i] !== m2[MSG_W-1-i]) bad++;
    check("t5_prefix", MSG_W'(bad), '0);
    base = out_bits.size();
    m1 = rand_msg();
    send_msg(m1, MODE_LFSR, MSG_W);
    idle(3);
    grab(base, MSG_W, got);
    check("t5_full", got, model(m1, key, 1'b1));

    // Enable freeze mid-message, then reset mid-message.
    base = out_bits.size();
    m1 = rand_msg();
    md = 1'($urandom_range(0, 1));
    send_msg(m1, md, 200);
    for (int i = 0; i < 5; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), ~md, 1'b0);
      if (i == 2) check("t6_freeze_start", MSG_W'(oSerial_start), '0);
    end
    for (int i = 200; i < MSG_W; i++) cyc(1'b0, 1'b1, m1[MSG_W-1-i], md, 1'b1);
    idle(3);
    check("t6_count", MSG_W'(out_bits.size() - base), MSG_W'(MSG_W));
    grab(base, MSG_W, got);
    check("t6_resume", got, model(m1, key, md));
    e0 = end_idx.size();
    send_msg(rand_msg(), 1'b0, 300);
    iRst = 1'b0;
    #2;
    check("rst_out",   MSG_W'(oSerial_out),   '0);
    check("rst_start", MSG_W'(oSerial_start), '0);
    check("rst_end",   MSG_W'(oSerial_end),   '0);
    check("rst_error", MSG_W'(oError),        '0);
    check("rst_ready", MSG_W'(oKey_ready),    '0);
    check("rst_state", MSG_W'(dut.state_q),   MSG_W'(IDLE));
    iLoad_msg = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b1;
    idle(3);
    check("rst_no_end", MSG_W'(end_idx.size() - e0), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_xor_stream_cipher
`default_nettype wire

// File: doc/xor_stream_cipher.md
# xor_stream_cipher

Parametrised streaming XOR cipher that replaces the fixed 32-bit key / 512-bit message encryption top. It loads a KEY_W-bit key serially and then encrypts MSG_W-bit messages bit by bit as they arrive, so no full-message buffer is needed. Each output bit appears one cycle after its input bit. It supports two keystream modes, repeating key and LFSR-expanded key, and keeps the key for back-to-back messages. It flags protocol errors instead of silently corrupting output.

## Interface
- KEY_W, 32: key length in bits, ≥ 2.
- MSG_W, 512: message length in bits, ≥ 1.
- LFSR_TAPS, 32'h8020_0003: Galois feedback mask, KEY_W wide. Bit 0 must be set.
- iClk  in  1  system clock.
- iRst  in  1  reset, asynchronous, active-low.
- iEn  in  1  global enable; when low, all state and counters freeze.
- iLoad_key  in  1  key framing; high while key bits are presented.
- iLoad_msg  in  1  message framing; high while message bits are presented.
- iSerial_in  in  1  serial data, MSB first, for both key and message.
- iMode  in  1  0 = repeating key, 1 = LFSR keystream; sampled at message start.
- oSerial_out  out  1  ciphertext bit, registered.
- oSerial_start  out  1  oSerial_out valid this cycle.
- oSerial_end  out  1  one-cycle pulse coincident with the last valid ciphertext bit.
- oKey_ready  out  1  a complete key is held.
- oError  out  1  one-cycle pulse on a protocol violation.

## Operation
- States: IDLE (no key), LOAD_KEY, READY (key held), STREAM.
- When iEn = 0, nothing advances and oSerial_start/oSerial_end/oError are 0. When iEn returns to 1, operation resumes exactly where it stopped.
- Key load, from IDLE or READY with iLoad_key = 1:
  - Go to LOAD_KEY, clear oKey_ready, clear key_cnt.
  - Each enabled cycle: key_sr <= {key_sr[KEY_W-2:0], iSerial_in}, key_cnt++.
  - At key_cnt = KEY_W, set oKey_ready = 1 and go to READY. Further bits are ignored until iLoad_key falls.
  - A new rising iLoad_key restarts the load.
- Key load aborted (iLoad_key falls before KEY_W bits): pulse oError, discard the partial key, go to IDLE.
- Message start, READY with iLoad_msg = 1:
  - Latch iMode.
  - Load the working register w from key_sr.
  - Go to STREAM, clear msg_cnt.
- STREAM, each enabled cycle:
  - Keystream bit is ks = w[KEY_W-1].
  - oSerial_out <= iSerial_in ^ ks, oSerial_start <= 1, msg_cnt++.
  - Mode 0: w <= {w[KEY_W-2:0], w[KEY_W-1]} (rotate left).
  - Mode 1: w <= {w[KEY_W-2:0], 1'b0} ^ (w[KEY_W-1] ? LFSR_TAPS : 0).
- On the MSG_W-th bit: oSerial_end <= 1 and return to READY. The key is retained and w is reloaded at the next message start.
- iLoad_msg falls in STREAM before MSG_W bits: pulse oError, go to READY, no oSerial_end.
- iLoad_msg = 1 in IDLE or LOAD_KEY: pulse oError, ignore.
- iLoad_key and iLoad_msg both rising in the same cycle in READY: pulse oError, state unchanged.
- iLoad_key during STREAM: ignored.
- All-zero key in mode 1 gives an all-zero keystream. This is legal and no error is raised.
- Counters are $clog2(KEY_W+1) and $clog2(MSG_W+1) bits wide and never wrap.

## Timing
- Reset values: all outputs 0, key_sr 0, w 0, counters 0, state IDLE.
- Latency: an input bit sampled at edge n appears on oSerial_out after edge n+1.
- With iEn held high, oSerial_start is high for exactly MSG_W consecutive cycles per message.
- Key-ready latency: oKey_ready rises at the edge that samples key bit KEY_W-1.
- A new message may start the cycle after oSerial_end; no idle cycle is required.
- Reset asserted mid-operation clears everything immediately; a partial output message is not completed.

## Structure
- Package xor_cipher_pkg holds:
  - state enum {IDLE, LOAD_KEY, READY, STREAM};
  - mode constants MODE_REPEAT = 0 and MODE_LFSR = 1;
  - the default tap mask constant.
- Sub-module keystream_gen (parameters KEY_W, LFSR_TAPS; ports: load, step, mode, seed, ks bit) owns w and both update rules.
- The top holds the FSM, key shift register, counters and output registers.

## Test plan
- Default parameters, key 0xA5A5A5A5, mode 0, message all zeros -> ciphertext equals {16{32'hA5A5A5A5}}; oSerial_start high for 512 cycles; oSerial_end coincides with bit 0.
- Key 0x00000001, mode 1, message all zeros -> output bits 0..30 are 0, bit 31 is 1, bit 32 is 1 (w = 0x80200003), matching a reference LFSR model for all 512 bits.
- Two back-to-back messages 0xFF.. and 0x00.. with the same key, mode 0 -> each equals message ^ repeated key; the second begins the cycle after oSerial_end.
- iLoad_key dropped after 10 key bits -> single oError pulse, oKey_ready = 0; a subsequent iLoad_msg -> oError, no output.
- iLoad_msg dropped after 100 bits -> 100 valid output bits, oError pulse, no oSerial_end; the next full message is correct from key MSB.
- iEn low for 5 cycles mid-message, then iRst pulsed mid-message -> freeze then correct resume; after reset all outputs 0, oKey_ready 0, state IDLE.
